// File: rtl/mul_long_unit_if.sv
// mul_long_unit_if: request/result bundle between the controller and the
// iterative long multiplier. The master (controller side) drives the request
// and operands; the slave (the multiplier) drives the status and results.
interface mul_long_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       MulOp;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] ResultExtra;
   logic [1:0]       MulFlags;

   modport master (
      output start, MulOp, a, b,
      input  busy, done, Result, ResultExtra, MulFlags
   );

   modport slave (
      input  start, MulOp, a, b,
      output busy, done, Result, ResultExtra, MulFlags
   );
endinterface

// File: rtl/mul_long_unit.sv
// mul_long_unit: iterative shift-add multiplier for MUL, UMULL and SMULL.
// One multiplier bit is consumed per cycle (LSB first). Signed operands are
// converted to magnitudes on accept and the product is negated in FIX.
// Optional build macro MUL_EARLY_TERM_EN: when defined, RUN exits as soon as
// the unconsumed multiplier bits are all zero, applying the outstanding shift
// in a single step. When undefined the latency is fixed at WIDTH+2 cycles.
module mul_long_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic            clk,
   input logic            reset,
   mul_long_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } stateType;

   stateType           state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic               neg;
   logic               isLong;
   logic               busyReg;
   logic               doneReg;
   logic [WIDTH-1:0]   resultReg;
   logic [WIDTH-1:0]   resultExtraReg;
   logic [1:0]         flagsReg;

   logic [WIDTH:0]     partialSum;
   logic [2*WIDTH-1:0] stepProd;
   logic               lastIter;

   // One shift-add step: conditional add into the high half keeping the
   // carry, then shift {carry, high, low/multiplier} right by one.
   always_comb begin
      partialSum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      stepProd   = {partialSum, prod[WIDTH-1:1]};
      lastIter   = (cnt == CNT_W'(WIDTH - 1));
   end

`ifdef MUL_EARLY_TERM_EN
   logic [WIDTH-1:0]   restMask;
   logic               restZero;
   logic [CNT_W-1:0]   restShift;
   logic [2*WIDTH-1:0] earlyProd;

   // After this step the unconsumed multiplier bits sit in the bottom
   // WIDTH-1-cnt bits of the low half; if they are zero, finish the shift now.
   always_comb begin
      restMask  = {WIDTH{1'b1}} >> (cnt + CNT_W'(1));
      restZero  = ((stepProd[WIDTH-1:0] & restMask) == '0) && !lastIter;
      restShift = CNT_W'(WIDTH - 1) - cnt;
      earlyProd = stepProd >> restShift;
   end
`endif

   // Control FSM and datapath registers: accept, iterate, sign-fix, publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         mcand          <= '0;
         prod           <= '0;
         neg            <= 1'b0;
         isLong         <= 1'b0;
         busyReg        <= 1'b0;
         doneReg        <= 1'b0;
         resultReg      <= '0;
         resultExtraReg <= '0;
         flagsReg       <= '0;
      end else begin
         case (state)
            IDLE: begin
               doneReg <= 1'b0;
               if (bus.start) begin
                  if (bus.MulOp == 2'b11) begin
                     mcand <= bus.a[WIDTH-1] ? ('0 - bus.a) : bus.a;
                     prod  <= {{WIDTH{1'b0}}, (bus.b[WIDTH-1] ? ('0 - bus.b) : bus.b)};
                     neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  end else begin
                     mcand <= bus.a;
                     prod  <= {{WIDTH{1'b0}}, bus.b};
                     neg   <= 1'b0;
                  end
                  isLong  <= bus.MulOp[1];
                  cnt     <= '0;
                  busyReg <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
`ifdef MUL_EARLY_TERM_EN
               if (restZero) begin
                  prod  <= earlyProd;
                  state <= FIX;
               end else begin
                  prod <= stepProd;
                  cnt  <= cnt + CNT_W'(1);
                  if (lastIter) begin
                     state <= FIX;
                  end
               end
`else
               prod <= stepProd;
               cnt  <= cnt + CNT_W'(1);
               if (lastIter) begin
                  state <= FIX;
               end
`endif
            end
            FIX: begin
               if (neg) begin
                  prod <= '0 - prod;
               end
               state <= DONE;
            end
            DONE: begin
               resultReg      <= prod[WIDTH-1:0];
               resultExtraReg <= isLong ? prod[2*WIDTH-1:WIDTH] : '0;
               if (isLong) begin
                  flagsReg <= {prod[2*WIDTH-1], (prod == '0)};
               end else begin
                  flagsReg <= {prod[WIDTH-1], (prod[WIDTH-1:0] == '0)};
               end
               doneReg <= 1'b1;
               busyReg <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busyReg;
   assign bus.done        = doneReg;
   assign bus.Result      = resultReg;
   assign bus.ResultExtra = resultExtraReg;
   assign bus.MulFlags    = flagsReg;

endmodule

// File: tb/tb_mul_long_unit.sv
// tb_mul_long_unit: randomized and directed checks of mul_long_unit against
// a 64-bit arithmetic reference model. Honours MUL_EARLY_TERM_EN for latency.
module tb_mul_long_unit;

   localparam int WIDTH = 32;
`ifdef MUL_EARLY_TERM_EN
   localparam bit EarlyTerm = 1'b1;
`else
   localparam bit EarlyTerm = 1'b0;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ext;
      logic [31:0] res;
      logic [1:0]  flg;
   } vecT;

   logic clk;
   logic reset;
   int   checkCount = 0;
   int   passCount  = 0;

   mul_long_unit_if #(.WIDTH(WIDTH)) mulBus ();

   mul_long_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mulBus)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product from plain 64-bit arithmetic.
   function automatic void refModel(input logic [1:0] op, input logic [31:0] av,
                                    input logic [31:0] bv, output logic [31:0] eRes,
                                    output logic [31:0] eExt, output logic [1:0] eFlg);
      logic [63:0] p;
      logic [31:0] lo;
      longint      sa;
      longint      sb;
      if (op[1] == 1'b0) begin
         lo   = av * bv;
         eRes = lo;
         eExt = 32'd0;
         eFlg = {lo[31], (lo == 32'd0)};
      end else begin
         if (op[0]) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            p  = 64'(sa * sb);
         end else begin
            p = {32'd0, av} * {32'd0, bv};
         end
         eRes = p[31:0];
         eExt = p[63:32];
         eFlg = {p[63], (p == 64'd0)};
      end
   endfunction

   // Cycles from the accept edge to the edge that raises done.
   function automatic int expectedLatency(input logic [1:0] op, input logic [31:0] bv);
      logic [31:0] mag;
      int          top;
      mag = (op == 2'b11 && bv[31]) ? (32'd0 - bv) : bv;
      top = 0;
      for (int i = 0; i < 32; i++) begin
         if (mag[i]) top = i;
      end
      return EarlyTerm ? (3 + top) : (WIDTH + 2);
   endfunction

   // Issue one operation and wait (bounded) for its done pulse.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av,
                                input logic [31:0] bv, output int lat,
                                output bit timedOut, output logic busyAfter,
                                output logic busyAtDone, output logic [31:0] res,
                                output logic [31:0] ext, output logic [1:0] flg);
      @(negedge clk);
      mulBus.start = 1'b1;
      mulBus.MulOp = op;
      mulBus.a     = av;
      mulBus.b     = bv;
      @(posedge clk);
      @(negedge clk);
      mulBus.start = 1'b0;
      mulBus.a     = $urandom;
      mulBus.b     = $urandom;
      mulBus.MulOp = 2'($urandom);
      busyAfter    = mulBus.busy;
      lat          = 0;
      timedOut     = 1'b1;
      for (int i = 0; i < 100 && timedOut; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (mulBus.done === 1'b1) timedOut = 1'b0;
      end
      busyAtDone = mulBus.busy;
      res        = mulBus.Result;
      ext        = mulBus.ResultExtra;
      flg        = mulBus.MulFlags;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      mulBus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (mulBus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", mulBus.busy);
      else passCount++;
      checkCount++;
      if (mulBus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", mulBus.done);
      else passCount++;
      checkCount++;
      if (mulBus.Result !== 32'd0) $display("[TB] FAIL reset_result: got %h expected 0", mulBus.Result);
      else passCount++;
      checkCount++;
      if (mulBus.ResultExtra !== 32'd0) $display("[TB] FAIL reset_extra: got %h expected 0", mulBus.ResultExtra);
      else passCount++;
      checkCount++;
      if (mulBus.MulFlags !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", mulBus.MulFlags);
      else passCount++;
      reset = 1'b0;
   endtask

   task automatic test_directed();
      vecT         v[$];
      int          lat;
      bit          tOut;
      logic        bA, bD;
      logic [31:0] res, ext;
      logic [1:0]  flg;
      v.push_back(vecT'{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2'b10});
      v.push_back(vecT'{2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 2'b10});
      v.push_back(vecT'{2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2'b00});
      v.push_back(vecT'{2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 2'b01});
      v.push_back(vecT'{2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 2'b00});
      v.push_back(vecT'{2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 2'b00});
      foreach (v[k]) begin
         applyStimulus(v[k].op, v[k].a, v[k].b, lat, tOut, bA, bD, res, ext, flg);
         checkCount++;
         if (tOut) $display("[TB] FAIL dir_timeout[%0d]: got no done expected done", k);
         else passCount++;
         checkCount++;
         if (res !== v[k].res) $display("[TB] FAIL dir_result[%0d]: got %h expected %h", k, res, v[k].res);
         else passCount++;
         checkCount++;
         if (ext !== v[k].ext) $display("[TB] FAIL dir_extra[%0d]: got %h expected %h", k, ext, v[k].ext);
         else passCount++;
         checkCount++;
         if (flg !== v[k].flg) $display("[TB] FAIL dir_flags[%0d]: got %b expected %b", k, flg, v[k].flg);
         else passCount++;
         checkCount++;
         if (lat !== expectedLatency(v[k].op, v[k].b))
            $display("[TB] FAIL dir_latency[%0d]: got %0d expected %0d", k, lat, expectedLatency(v[k].op, v[k].b));
         else passCount++;
         checkCount++;
         if (bA !== 1'b1) $display("[TB] FAIL dir_busy_run[%0d]: got %b expected 1", k, bA);
         else passCount++;
         checkCount++;
         if (bD !== 1'b0) $display("[TB] FAIL dir_busy_done[%0d]: got %b expected 0", k, bD);
         else passCount++;
         @(negedge clk);
         checkCount++;
         if (mulBus.done !== 1'b0) $display("[TB] FAIL dir_done_pulse[%0d]: got %b expected 0", k, mulBus.done);
         else passCount++;
      end
   endtask

   task automatic test_random();
      logic [31:0] corners[4] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
      logic [1:0]  op;
      logic [31:0] av, bv, res, ext, eRes, eExt;
      logic [1:0]  flg, eFlg;
      int          lat;
      bit          tOut;
      logic        bA, bD;
      for (int n = 0; n < 20; n++) begin
         op = 2'($urandom_range(0, 3));
         av = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
         bv = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
         refModel(op, av, bv, eRes, eExt, eFlg);
         applyStimulus(op, av, bv, lat, tOut, bA, bD, res, ext, flg);
         checkCount++;
         if (tOut) $display("[TB] FAIL rnd_timeout[%0d]: got no done expected done", n);
         else passCount++;
         checkCount++;
         if (res !== eRes) $display("[TB] FAIL rnd_result[%0d] op=%b a=%h b=%h: got %h expected %h", n, op, av, bv, res, eRes);
         else passCount++;
         checkCount++;
         if (ext !== eExt) $display("[TB] FAIL rnd_extra[%0d] op=%b a=%h b=%h: got %h expected %h", n, op, av, bv, ext, eExt);
         else passCount++;
         checkCount++;
         if (flg !== eFlg) $display("[TB] FAIL rnd_flags[%0d]: got %b expected %b", n, flg, eFlg);
         else passCount++;
         checkCount++;
         if (lat !== expectedLatency(op, bv))
            $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, expectedLatency(op, bv));
         else passCount++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] bFix, pendA, eRes, eExt;
      logic [1:0]  eFlg;
      bit          acceptPending;
      int          sinceAccept, opsSeen;
      bFix = $urandom;
      @(negedge clk);
      mulBus.MulOp  = 2'b10;
      mulBus.b      = bFix;
      mulBus.a      = $urandom;
      mulBus.start  = 1'b1;
      acceptPending = 1'b1;
      opsSeen       = 0;
      sinceAccept   = 0;
      pendA         = 32'd0;
      for (int cyc = 0; cyc < 400 && opsSeen < 3; cyc++) begin
         @(posedge clk);
         if (acceptPending) begin
            pendA         = mulBus.a;
            acceptPending = 1'b0;
            sinceAccept   = 0;
         end else begin
            sinceAccept++;
         end
         @(negedge clk);
         if (mulBus.done === 1'b1) begin
            refModel(2'b10, pendA, bFix, eRes, eExt, eFlg);
            checkCount++;
            if ({mulBus.ResultExtra, mulBus.Result} !== {eExt, eRes})
               $display("[TB] FAIL b2b_product[%0d]: got %h expected %h", opsSeen,
                        {mulBus.ResultExtra, mulBus.Result}, {eExt, eRes});
            else passCount++;
            checkCount++;
            if (mulBus.MulFlags !== eFlg) $display("[TB] FAIL b2b_flags[%0d]: got %b expected %b", opsSeen, mulBus.MulFlags, eFlg);
            else passCount++;
            checkCount++;
            if (sinceAccept !== expectedLatency(2'b10, bFix))
               $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", opsSeen, sinceAccept, expectedLatency(2'b10, bFix));
            else passCount++;
            opsSeen++;
            acceptPending = 1'b1;
            if (opsSeen == 3) mulBus.start = 1'b0;
         end
         mulBus.a = $urandom;
      end
      mulBus.start = 1'b0;
      checkCount++;
      if (opsSeen !== 3) $display("[TB] FAIL b2b_done_count: got %0d expected 3", opsSeen);
      else passCount++;
   endtask

   task automatic test_reset_midop();
      logic [31:0] av, bv, res, ext, eRes, eExt;
      logic [1:0]  flg, eFlg;
      int          lat, doneSeen;
      bit          tOut;
      logic        bA, bD;
      applyStimulus(2'b10, 32'd7, 32'd6, lat, tOut, bA, bD, res, ext, flg);
      checkCount++;
      if (res !== 32'd42) $display("[TB] FAIL rst_pre_result: got %h expected %h", res, 32'd42);
      else passCount++;
      @(negedge clk);
      mulBus.start = 1'b1;
      mulBus.MulOp = 2'b10;
      mulBus.a     = $urandom | 32'd1;
      mulBus.b     = $urandom | 32'd1;
      @(posedge clk);
      @(negedge clk);
      mulBus.start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkCount++;
      if (mulBus.busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b expected 0", mulBus.busy);
      else passCount++;
      checkCount++;
      if (mulBus.Result !== 32'd0) $display("[TB] FAIL rst_mid_result: got %h expected 0", mulBus.Result);
      else passCount++;
      checkCount++;
      if (mulBus.ResultExtra !== 32'd0) $display("[TB] FAIL rst_mid_extra: got %h expected 0", mulBus.ResultExtra);
      else passCount++;
      checkCount++;
      if (mulBus.MulFlags !== 2'b00) $display("[TB] FAIL rst_mid_flags: got %b expected 00", mulBus.MulFlags);
      else passCount++;
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (mulBus.done === 1'b1) doneSeen++;
      end
      checkCount++;
      if (doneSeen !== 0) $display("[TB] FAIL rst_mid_no_done: got %0d pulses expected 0", doneSeen);
      else passCount++;
      av = $urandom;
      bv = $urandom;
      refModel(2'b10, av, bv, eRes, eExt, eFlg);
      applyStimulus(2'b10, av, bv, lat, tOut, bA, bD, res, ext, flg);
      checkCount++;
      if (tOut || {ext, res} !== {eExt, eRes})
         $display("[TB] FAIL rst_after_product: got %h expected %h (timeout=%0d)", {ext, res}, {eExt, eRes}, tOut);
      else passCount++;
      checkCount++;
      if (flg !== eFlg) $display("[TB] FAIL rst_after_flags: got %b expected %b", flg, eFlg);
      else passCount++;
   endtask

`ifdef MUL_EARLY_TERM_EN
   task automatic test_early_term();
      logic [31:0] res, ext;
      logic [1:0]  flg;
      int          lat;
      bit          tOut;
      logic        bA, bD;
      applyStimulus(2'b10, 32'd3, 32'd5, lat, tOut, bA, bD, res, ext, flg);
      checkCount++;
      if ({ext, res} !== 64'd15) $display("[TB] FAIL early_product: got %h expected %h", {ext, res}, 64'd15);
      else passCount++;
      checkCount++;
      if (lat !== 5) $display("[TB] FAIL early_latency: got %0d expected 5", lat);
      else passCount++;
      applyStimulus(2'b10, $urandom, 32'd0, lat, tOut, bA, bD, res, ext, flg);
      checkCount++;
      if ({ext, res} !== 64'd0 || flg !== 2'b01)
         $display("[TB] FAIL early_zero: got %h/%b expected 0/01", {ext, res}, flg);
      else passCount++;
      checkCount++;
      if (lat !== 3) $display("[TB] FAIL early_zero_latency: got %0d expected 3", lat);
      else passCount++;
   endtask
`endif

   // Test sequence and summary.
   initial begin
      reset        = 1'b1;
      mulBus.start = 1'b0;
      mulBus.MulOp = 2'b00;
      mulBus.a     = 32'd0;
      mulBus.b     = 32'd0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midop();
`ifdef MUL_EARLY_TERM_EN
      test_early_term();
`endif
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
